// File: rtl/sorted_vector_serializer.sv
// Buffers whole sorted vectors in a small FIFO and replays them one element per
// cycle on a valid/ready stream, tagging each element with its index and a last flag.
module sorted_vector_serializer #(
  parameter int NUMBER_WIDTH   = 10,
  parameter int NUMBERS_AMOUNT = 10,
  parameter int FIFO_DEPTH     = 4,
  parameter int DESCENDING     = 0,
  localparam int IDX_W = (NUMBERS_AMOUNT > 1) ? $clog2(NUMBERS_AMOUNT) : 1
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_i,
  input  logic                                         data_valid_i,
  output logic [NUMBER_WIDTH-1:0]                      data_o,
  output logic [IDX_W-1:0]                             data_idx_o,
  output logic                                         data_valid_o,
  output logic                                         data_last_o,
  input  logic                                         data_ready_i,
  output logic                                         overflow_o,
  output logic                                         fifo_full_o,
  output logic                                         fifo_empty_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBERS_AMOUNT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] vec_t;
  typedef enum logic {IDLE, SEND} state_t;

  vec_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             fifo_full, fifo_empty;
  logic             push, pop;

  state_t           state_q, state_n;
  vec_t             vec_q, vec_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [IDX_W-1:0] sel;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = data_valid_i && (!fifo_full || pop);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
      if (data_valid_i && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      vec_q   <= vec_n;
      idx_q   <= idx_n;
    end
  end

  // Stream handshake: an element transfers on a cycle where data_valid_o and
  // data_ready_i are both high; while valid is high and ready low, data/idx/last hold.
  always_comb begin
    state_n = state_q;
    vec_n   = vec_q;
    idx_n   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          vec_n   = mem_q[rd_ptr_q];
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (data_ready_i) begin
          if (idx_q == LAST_IDX) begin
            if (!fifo_empty) begin
              pop   = 1'b1;
              vec_n = mem_q[rd_ptr_q];
              idx_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sel          = (DESCENDING != 0) ? (LAST_IDX - idx_q) : idx_q;
  assign data_o       = vec_q[sel];
  assign data_idx_o   = idx_q;
  assign data_valid_o = (state_q == SEND);
  assign data_last_o  = data_valid_o && (idx_q == LAST_IDX);
  assign overflow_o   = overflow_q;
  assign fifo_full_o  = fifo_full;
  assign fifo_empty_o = fifo_empty;

endmodule

// File: tb/tb_sorted_vector_serializer.sv
// Directed bench: an ascending instance checked through an expected-element queue,
// and a descending instance used for ordering and mid-vector reset.
module tb_sorted_vector_serializer;

  localparam int W = 8;
  localparam int N = 4;
  localparam int D = 4;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  vec_t           din = '0;
  logic           a_valid_in = 1'b0, d_valid_in = 1'b0;
  logic           a_ready = 1'b1, d_ready = 1'b1;
  logic [W-1:0]   a_data, d_data;
  logic [1:0]     a_idx, d_idx;
  logic           a_valid, d_valid, a_last, d_last;
  logic           a_ovf, d_ovf, a_full, d_full, a_empty, d_empty;

  int             n_checks = 0;
  int             n_errors = 0;
  logic [10:0]    exp_q[$];
  logic           rdy_q[$];

  always #5 clk = ~clk;

  sorted_vector_serializer #(.NUMBER_WIDTH(W), .NUMBERS_AMOUNT(N), .FIFO_DEPTH(D), .DESCENDING(0)) u_asc (
    .clk_i(clk), .rst_i(rst), .data_i(din), .data_valid_i(a_valid_in),
    .data_o(a_data), .data_idx_o(a_idx), .data_valid_o(a_valid), .data_last_o(a_last),
    .data_ready_i(a_ready), .overflow_o(a_ovf), .fifo_full_o(a_full), .fifo_empty_o(a_empty)
  );

  sorted_vector_serializer #(.NUMBER_WIDTH(W), .NUMBERS_AMOUNT(N), .FIFO_DEPTH(D), .DESCENDING(1)) u_desc (
    .clk_i(clk), .rst_i(rst), .data_i(din), .data_valid_i(d_valid_in),
    .data_o(d_data), .data_idx_o(d_idx), .data_valid_o(d_valid), .data_last_o(d_last),
    .data_ready_i(d_ready), .overflow_o(d_ovf), .fifo_full_o(d_full), .fifo_empty_o(d_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] e0, e1, e2, e3);
    vec_t v;
    v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
    return v;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    a_valid_in = 1'b0;
    d_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; the vector is sampled on the next edge.
  task automatic drive_vec(input vec_t v, input bit to_d);
    din = v;
    if (to_d) d_valid_in = 1'b1; else a_valid_in = 1'b1;
    @(posedge clk); #1;
    a_valid_in = 1'b0;
    d_valid_in = 1'b0;
  endtask

  task automatic exp_vec(input vec_t v);
    for (int k = 0; k < N; k++)
      exp_q.push_back({v[k], 2'(k), 1'(k == N - 1)});
  endtask

  // Scoreboard for the ascending instance; the ready pattern starts with the first valid.
  task automatic collect(input bit strict, input int budget);
    int cyc = 0;
    bit started = 1'b0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      if (strict) check("no_bubble", a_valid, 1);
      if (a_valid) begin
        started = 1'b1;
        check("elem", {a_data, a_idx, a_last}, exp_q[0]);
        if (a_ready) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
      if (started) a_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      cyc++;
    end
    if (exp_q.size() > 0) begin
      check("timeout_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check(tag, a_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    reset_dut();

    @(negedge clk);
    check("rst_valid", a_valid, 0);
    check("rst_last", a_last, 0);
    check("rst_data", a_data, 0);
    check("rst_idx", a_idx, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_full", a_full, 0);
    check("rst_empty", a_empty, 1);
    check("rst_d_valid", d_valid, 0);
    @(posedge clk); #1;

    // Single vector, two-cycle latency
    drive_vec(mk(1, 2, 3, 4), 0);
    @(negedge clk);
    check("t1_lat_valid", a_valid, 0);
    check("t1_lat_empty", a_empty, 0);
    exp_vec(mk(1, 2, 3, 4));
    collect(1, 20);
    expect_idle("t1_idle");

    // Back-to-back vectors without a bubble
    drive_vec(mk(1, 2, 3, 4), 0);
    drive_vec(mk(5, 6, 7, 8), 0);
    exp_vec(mk(1, 2, 3, 4));
    exp_vec(mk(5, 6, 7, 8));
    collect(1, 30);
    expect_idle("t2_idle");

    // Backpressure pattern 1,0,0,1,0,1,1
    a_ready = 1'b1;
    rdy_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    drive_vec(mk(9, 8, 7, 6), 0);
    exp_vec(mk(9, 8, 7, 6));
    collect(0, 30);
    rdy_q.delete();
    a_ready = 1'b1;
    expect_idle("t3_idle");

    // Overflow: six vectors while stalled, sixth dropped
    a_ready = 1'b0;
    for (int v = 1; v <= 6; v++)
      drive_vec(mk(8'(16*v), 8'(16*v+1), 8'(16*v+2), 8'(16*v+3)), 0);
    @(negedge clk);
    check("t4_ovf", a_ovf, 1);
    check("t4_full", a_full, 1);
    @(posedge clk); #1;
    for (int v = 1; v <= 5; v++)
      exp_vec(mk(8'(16*v), 8'(16*v+1), 8'(16*v+2), 8'(16*v+3)));
    a_ready = 1'b1;
    collect(0, 60);
    @(negedge clk);
    check("t4_ovf_sticky", a_ovf, 1);
    check("t4_empty", a_empty, 1);
    check("t4_no_sixth", a_valid, 0);
    @(posedge clk); #1;

    // Push into a full FIFO on the cycle the last element pops
    reset_dut();
    a_ready = 1'b0;
    for (int v = 1; v <= 5; v++)
      drive_vec(mk(8'(v), 8'(v+32), 8'(v+64), 8'(v+96)), 0);
    for (int v = 1; v <= 6; v++)
      exp_vec(mk(8'(v), 8'(v+32), 8'(v+64), 8'(v+96)));
    a_ready = 1'b1;
    fork
      collect(0, 80);
      begin
        repeat (3) begin @(posedge clk); #1; end
        check("t5_full", a_full, 1);
        drive_vec(mk(8'd6, 8'd38, 8'd70, 8'd102), 0);
      end
    join
    @(negedge clk);
    check("t5_ovf", a_ovf, 0);
    check("t5_idle", a_valid, 0);
    @(posedge clk); #1;

    // Descending order, then reset mid-vector with a vector still buffered
    reset_dut();
    d_ready = 1'b1;
    drive_vec(mk(1, 2, 3, 4), 1);
    drive_vec(mk(5, 6, 7, 8), 1);
    @(negedge clk);
    check("t6_e0_data", d_data, 4);
    check("t6_e0_idx", d_idx, 0);
    check("t6_e0_valid", d_valid, 1);
    @(negedge clk);
    check("t6_e1_data", d_data, 3);
    check("t6_e1_idx", d_idx, 1);
    check("t6_e1_last", d_last, 0);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", d_valid, 0);
    check("t6_rst_empty", d_empty, 1);
    check("t6_rst_ovf", d_ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (d_valid) vcount++;
    end
    check("t6_no_residue", vcount, 0);
    check("t6_empty_after", d_empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
